alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have clk input 1: system clock; all state updates on rising edge.
REQ-002 SHALL have resetn input 1: reset, asynchronous, active-low.
REQ-003 SHALL have req_valid input 1, req_ready output 1, req_op input 4 (ALU op code), req_a input 16 signed, req_b input 16 signed.
REQ-004 SHALL have alu_ctrl output 4, alu_a output 16, alu_b output 16: drive the ALU operand port.
REQ-005 SHALL have alu_y input 16 and alu_c, alu_z, alu_n, alu_v, alu_s inputs 1 each: ALU result and flags.
REQ-006 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_y output 16, rsp_flags output 5 ordered {s,v,n,z,c}.
REQ-007 SHALL have cond_code input 4 and cond_true output 1: branch condition test against the flags register.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, CAPTURE, DONE.
REQ-009 SHALL assert req_ready = (state==IDLE) | (state==DONE & rsp_ready).
REQ-010 SHALL on accept (req_valid & req_ready at an edge) load alu_ctrl/alu_a/alu_b from req_op/req_a/req_b and enter ISSUE.
REQ-011 SHALL hold alu_ctrl/alu_a/alu_b unchanged from accept until the next accept, so ALU y and the ctrl-dependent c/v stay stable through CAPTURE.
REQ-012 SHALL move ISSUE -> CAPTURE unconditionally at the next edge (the edge on which the ALU registers the operands).
REQ-013 SHALL at the CAPTURE -> DONE edge latch alu_y into rsp_y, the five flags into rsp_flags and into the flags register, and set rsp_valid.
REQ-014 SHALL keep rsp_valid, rsp_y, rsp_flags stable in DONE until rsp_ready is high at an edge.
REQ-015 SHALL on DONE with rsp_ready: enter ISSUE if req_valid (back-to-back accept), else IDLE; rsp_valid deasserts that edge either way.
REQ-016 SHALL give latency: accept at edge E0 -> rsp_valid high after edge E0+2; peak throughput one op per 3 cycles.
REQ-017 SHALL pass op codes 12..15 through unchanged; the result is whatever the ALU returns (0x0000), flags captured as presented.
REQ-018 SHALL ignore req_valid in ISSUE and CAPTURE (req_ready low).
REQ-019 SHALL compute cond_true combinationally from the flags register: 0 EQ z, 1 NE ~z, 2 CS c, 3 CC ~c, 4 MI n, 5 PL ~n, 6 VS v, 7 VC ~v, 8 LT s, 9 GE ~s, 10 GT ~z&~s, 11 LE z|s, 12 HI c&~z, 13 LS ~c|z, 14 AL 1, 15 NV 0.

Reset
REQ-020 SHALL on resetn low, at any state including mid ISSUE/CAPTURE, asynchronously force IDLE, rsp_valid=0, rsp_y=0, rsp_flags=0, flags register=0, alu_ctrl=0, alu_a=0, alu_b=0; an in-flight op is discarded with no response.
REQ-021 SHALL drive req_ready=0 while resetn low, and req_ready=1 from the first edge after release.

Configuration
REQ-022 SHALL with ALU_SEQ_COND_EN defined include the flags register and condition evaluator of REQ-019.
REQ-023 SHALL without ALU_SEQ_COND_EN tie cond_true to 0 and omit the flags register; rsp_flags behaviour is unchanged.

Structure
REQ-024 SHALL take ALU op code constants from the shared constants package; FSM state enum and cond-code constants (COND_EQ..COND_NV) SHALL be added to that package.
REQ-025 SHALL implement condition evaluation as sub-module alu_cond (flags in, cond_code in, cond_true out, combinational).

Verification
REQ-026 ADD 0x7FFF+0x0001 -> rsp_y=0x8000, rsp_flags {s,v,n,z,c}=5'b01100, rsp_valid high exactly 2 edges after accept.
REQ-027 SUB 0x0005-0x0005 -> rsp_y=0x0000, rsp_flags=5'b00010; then cond_code=0 (EQ) -> cond_true=1, cond_code=8 (LT) -> 0.
REQ-028 rsp_ready held low 4 cycles in DONE -> rsp_y/rsp_flags stable, req_ready low; rsp_ready high -> one handshake, rsp_valid low next cycle.
REQ-029 req_valid and rsp_ready both high in DONE (AND 0xF0F0,0x0FF0 next) -> direct DONE->ISSUE, next rsp_y=0x00F0 after 2 more edges.
REQ-030 resetn pulsed low in CAPTURE -> immediate IDLE, rsp_valid=0, rsp_flags=0, no response for the aborted op; next ADD 1+1 -> rsp_y=0x0002.
REQ-031 Built without ALU_SEQ_COND_EN, repeat REQ-027 -> cond_true=0 for all cond_code, rsp values identical.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared constants for the ALU sequencer slice.
//   ALU op codes (ALU_*), sequencer FSM state type (state_t),
//   branch condition codes (COND_EQ..COND_NV) and the packed flags type
//   ordered {s,v,n,z,c} as carried on rsp_flags.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOT   = 4'd5;
    localparam logic [3:0] ALU_SHL   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_SAR   = 4'd8;
    localparam logic [3:0] ALU_PASSA = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_NEG   = 4'd11;
    // 12..15 are unassigned: the ALU returns 0x0000 for them

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_LT = 4'd8;
    localparam logic [3:0] COND_GE = 4'd9;
    localparam logic [3:0] COND_GT = 4'd10;
    localparam logic [3:0] COND_LE = 4'd11;
    localparam logic [3:0] COND_HI = 4'd12;
    localparam logic [3:0] COND_LS = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef struct packed {
        logic s;
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/response bus of the ALU sequencer.
//   req_valid/req_ready/req_op/req_a/req_b : operation request
//   rsp_valid/rsp_ready/rsp_y/rsp_flags    : result response, flags {s,v,n,z,c}
//   master = requester side, slave = alu_seq side.
interface alu_seq_if;

    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_op;
    logic signed [15:0] req_a;
    logic signed [15:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [15:0]        rsp_y;
    logic [4:0]         rsp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_flags
    );

endinterface

// File: rtl/alu_cond.sv
// alu_cond -- combinational branch condition evaluator.
//   flags     : in,  flags register {s,v,n,z,c}
//   cond_code : in,  condition code COND_EQ..COND_NV
//   cond_true : out, condition holds for the given flags
module alu_cond
    import alu_seq_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] cond_code,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            COND_EQ: cond_true = flags.z;
            COND_NE: cond_true = ~flags.z;
            COND_CS: cond_true = flags.c;
            COND_CC: cond_true = ~flags.c;
            COND_MI: cond_true = flags.n;
            COND_PL: cond_true = ~flags.n;
            COND_VS: cond_true = flags.v;
            COND_VC: cond_true = ~flags.v;
            COND_LT: cond_true = flags.s;
            COND_GE: cond_true = ~flags.s;
            COND_GT: cond_true = ~flags.z & ~flags.s;
            COND_LE: cond_true = flags.z | flags.s;
            COND_HI: cond_true = flags.c & ~flags.z;
            COND_LS: cond_true = ~flags.c | flags.z;
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequencer that feeds one request at a time to a registered ALU
// and returns its result and flags.
//   clk, resetn (async, active-low)
//   bus       : alu_seq_if.slave request/response bus
//   alu_ctrl/alu_a/alu_b : operand port to the ALU, held from accept to accept
//   alu_y, alu_c/z/n/v/s : ALU result and flags
//   cond_code/cond_true  : condition test against the flags register
// Optional feature macro: ALU_SEQ_COND_EN (flags register + condition
// evaluator); without it cond_true is tied to 0.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    alu_seq_if.slave    bus,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        alu_s,
    input  logic [3:0]  cond_code,
    output logic        cond_true
);

    state_t state, state_nxt;
    logic   accept;
    flags_t alu_flags;
    flags_t cond_flags;
    logic   cond_eval;

    assign alu_flags = {alu_s, alu_v, alu_n, alu_z, alu_c};

    // Gated by resetn so nothing is offered while reset is held.
    assign bus.req_ready = resetn & ((state == IDLE) | ((state == DONE) & bus.rsp_ready));
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = accept ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_ctrl      <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_flags <= '0;
        end else begin
            if (accept) begin
                alu_ctrl <= bus.req_op;
                alu_a    <= bus.req_a;
                alu_b    <= bus.req_b;
            end
            // ALU output reflects the operands registered on the ISSUE edge
            if (state == CAPTURE) begin
                bus.rsp_y     <= alu_y;
                bus.rsp_flags <= alu_flags;
                bus.rsp_valid <= 1'b1;
            end else if ((state == DONE) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

    // Evaluator stays instantiated in both builds; without the feature its
    // input is constant and its output unused, so it folds away.
    alu_cond u_cond (
        .flags     (cond_flags),
        .cond_code (cond_code),
        .cond_true (cond_eval)
    );

`ifdef ALU_SEQ_COND_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               cond_flags <= '0;
        else if (state == CAPTURE) cond_flags <= alu_flags;
    end
    assign cond_true = cond_eval;
`else
    logic unused_cond;
    assign cond_flags  = '0;
    assign cond_true   = 1'b0;
    assign unused_cond = cond_eval;
`endif

endmodule
